// File: rtl/out_slice_fifo.sv
// Output FIFO between the pixel pipeline and the display interface. Each entry
// carries its SOF tag; an SOF write flushes the FIFO and reloads the active depth.
module out_slice_fifo #(
  parameter int NUM_LANES       = 4,
  parameter int LANE_WIDTH      = 42,
  parameter int DATA_WIDTH      = NUM_LANES * LANE_WIDTH,
  parameter int MAX_SLICE_WIDTH = 2560,
  parameter int DEPTH_SHIFT     = 1,
  parameter int MAX_DEPTH       = MAX_SLICE_WIDTH >> DEPTH_SHIFT,
  parameter int ADDR_WIDTH      = $clog2(MAX_DEPTH),
  parameter int CNT_WIDTH       = $clog2(MAX_DEPTH + 1),
  parameter int SW_WIDTH        = $clog2(MAX_SLICE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SW_WIDTH-1:0]   slice_width,
  input  logic [CNT_WIDTH-1:0]  af_margin,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic                  out_rd_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_sof,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [CNT_WIDTH-1:0]  fullness,
  output logic                  overflow,
  output logic                  underflow
);

  function automatic logic [CNT_WIDTH-1:0] clamp_depth(input logic [SW_WIDTH-1:0] sw);
    logic [SW_WIDTH-1:0] raw;
    raw = sw >> DEPTH_SHIFT;
    if (raw < SW_WIDTH'(2))              return CNT_WIDTH'(2);
    else if (raw > SW_WIDTH'(MAX_DEPTH)) return CNT_WIDTH'(MAX_DEPTH);
    else                                 return CNT_WIDTH'(raw);
  endfunction

  // Saturating threshold: a margin at or above depth pins almost_full high.
  function automatic logic [CNT_WIDTH-1:0] af_thr(input logic [CNT_WIDTH-1:0] dep,
                                                  input logic [CNT_WIDTH-1:0] mar);
    return (mar >= dep) ? '0 : dep - mar;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p,
                                                    input logic [CNT_WIDTH-1:0]  dep);
    return (CNT_WIDTH'(p) == dep - CNT_WIDTH'(1)) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  logic [DATA_WIDTH:0]   mem [MAX_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
  logic [CNT_WIDTH-1:0]  fullness_q, fullness_d, depth_q, depth_d, depth_new, depth_cur;
  logic                  load_pend_q;
  logic                  ovf_q, ovf_d, udf_q, udf_d, af_q, af_d, out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_sof_q;
  logic                  sof_wr, empty_c, rd_acc, wr_acc;

  always_comb begin
    depth_new  = clamp_depth(slice_width);
    // The first cycle after reset already runs with the freshly loaded depth.
    depth_cur  = load_pend_q ? depth_new : depth_q;
    sof_wr     = in_valid & in_sof;
    empty_c    = (fullness_q == '0);
    rd_acc     = out_rd_en & ~empty_c & ~sof_wr;
    wr_acc     = in_valid & (in_sof | (fullness_q < depth_cur) | rd_acc);
    wr_addr    = sof_wr ? '0 : wr_ptr_q;
    depth_d    = (load_pend_q | sof_wr) ? depth_new : depth_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fullness_d = fullness_q;
    if (sof_wr) begin
      wr_ptr_d   = ADDR_WIDTH'(1);
      rd_ptr_d   = '0;
      fullness_d = CNT_WIDTH'(1);
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q, depth_cur);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q, depth_cur);
      if (wr_acc && !rd_acc)      fullness_d = fullness_q + CNT_WIDTH'(1);
      else if (!wr_acc && rd_acc) fullness_d = fullness_q - CNT_WIDTH'(1);
    end
    ovf_d       = (ovf_q & ~err_clr) | (in_valid & ~wr_acc);
    udf_d       = (udf_q & ~err_clr) | (out_rd_en & empty_c & ~sof_wr);
    af_d        = (fullness_d >= af_thr(depth_d, af_margin));
    out_valid_d = rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fullness_q  <= '0;
      depth_q     <= CNT_WIDTH'(MAX_DEPTH);
      load_pend_q <= 1'b1;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      af_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fullness_q  <= fullness_d;
      depth_q     <= depth_d;
      load_pend_q <= 1'b0;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      af_q        <= af_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= {in_sof, in_data};
  end

  // Read port: read-before-write, so a full-FIFO rd+wr to one address returns old data.
  always_ff @(posedge clk) begin
    if (rst)         {out_sof_q, out_data_q} <= '0;
    else if (rd_acc) {out_sof_q, out_data_q} <= mem[rd_ptr_q];
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_sof     = out_sof_q;
  assign empty       = empty_c;
  assign full        = (fullness_q == depth_cur);
  assign almost_full = af_q;
  assign fullness    = fullness_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

endmodule

// File: tb/tb_out_slice_fifo.sv
// Bench for out_slice_fifo: directed stimulus, expected read words queued in a
// scoreboard and checked by an independent monitor on the falling edge.
module tb_out_slice_fifo;
  localparam int DW = 168;
  localparam int CW = 11;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] slice_width;
  logic [CW-1:0] af_margin;
  logic [DW-1:0] in_data;
  logic          in_valid, in_sof, out_rd_en, err_clr;
  logic [DW-1:0] out_data;
  logic          out_valid, out_sof, empty, full, almost_full, overflow, underflow;
  logic [CW-1:0] fullness;

  out_slice_fifo dut (
    .clk(clk), .rst(rst), .slice_width(slice_width), .af_margin(af_margin),
    .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .out_rd_en(out_rd_en),
    .err_clr(err_clr), .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof),
    .empty(empty), .full(full), .almost_full(almost_full), .fullness(fullness),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
    logic [31:0]   c;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] w(input int n);
    return {42'(n + 3), 42'(n + 2), 42'(n + 1), 42'(n) ^ 42'h2A5_0000_0000};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_rd(input logic [DW-1:0] d, input logic s);
    exp_t e;
    e.d = d; e.s = s; e.c = cyc + 1;
    sb.push_back(e);
  endtask

  // One clock: drive inputs, cross the rising edge, release strobes.
  task automatic step(input logic v, input logic s, input logic [DW-1:0] d, input logic rd);
    in_valid = v; in_sof = s; in_data = d; out_rd_en = rd;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; out_rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got out_valid=1 data=%h expected no output", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_data !== e.d || out_sof !== e.s || cyc != e.c) begin
          errors++;
          $display("FAIL rd_word: got data=%h sof=%0d cyc=%0d expected data=%h sof=%0d cyc=%0d",
                   out_data, out_sof, cyc, e.d, e.s, e.c);
        end
      end
    end else if (sb.size() != 0 && sb[0].c < cyc) begin
      checks++;
      errors++;
      $display("FAIL rd_missing: got out_valid=0 expected data=%h at cyc %0d", sb[0].d, sb[0].c);
      void'(sb.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish before 400000ns");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; slice_width = 12'd16; af_margin = 11'd2; in_data = '0;
    in_valid = 1'b0; in_sof = 1'b0; out_rd_en = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    idle(); idle();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(|out_data), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_fullness", 32'(fullness), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
    rst = 1'b0;
    idle();

    // Fill depth 8, margin 2 -> threshold 6
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, w(i), 1'b0);
      chk("fill_fullness", 32'(fullness), 32'(i + 1));
      if (i == 4) chk("af_at5", 32'(almost_full), 0);
      if (i == 5) chk("af_at6", 32'(almost_full), 1);
      if (i == 6) chk("full_at7", 32'(full), 0);
    end
    chk("full_at8", 32'(full), 1);
    step(1'b1, 1'b0, w(99), 1'b0);
    chk("ovf_drop", 32'(overflow), 1);
    chk("ovf_fullness", 32'(fullness), 8);

    // Drain in order
    for (int i = 0; i < 8; i++) begin
      expect_rd(w(i), 1'b0);
      step(1'b0, 1'b0, '0, 1'b1);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_af", 32'(almost_full), 0);
    chk("udf_before", 32'(underflow), 0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("udf_set", 32'(underflow), 1);
    chk("udf_no_valid", 32'(out_valid), 0);

    err_clr = 1'b1;
    idle();
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_udf", 32'(underflow), 0);
    err_clr = 1'b1;
    step(1'b0, 1'b0, '0, 1'b1);
    chk("clr_vs_udf", 32'(underflow), 1);
    chk("clr_vs_udf_ovf", 32'(overflow), 0);

    // Streaming with three in flight: pointers wrap twice
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, w(100 + i), 1'b0);
    for (int k = 0; k < 17; k++) begin
      expect_rd(w(100 + k), 1'b0);
      step(1'b1, 1'b0, w(103 + k), 1'b1);
      chk("stream_fullness", 32'(fullness), 3);
    end
    for (int k = 17; k < 20; k++) begin
      expect_rd(w(100 + k), 1'b0);
      step(1'b0, 1'b0, '0, 1'b1);
    end
    chk("stream_empty", 32'(empty), 1);

    // Mid-slice SOF flush with a coincident (discarded) read
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, w(200 + i), 1'b0);
    chk("pre_sof_fullness", 32'(fullness), 5);
    slice_width = 12'd8;
    step(1'b1, 1'b1, w(300), 1'b1);
    chk("sof_fullness", 32'(fullness), 1);
    chk("sof_full", 32'(full), 0);
    chk("sof_af", 32'(almost_full), 0);
    step(1'b1, 1'b0, w(301), 1'b0);
    chk("d4_af_at2", 32'(almost_full), 1);
    step(1'b1, 1'b0, w(302), 1'b0);
    chk("d4_full_at3", 32'(full), 0);
    step(1'b1, 1'b0, w(303), 1'b0);
    chk("d4_full_at4", 32'(full), 1);
    expect_rd(w(300), 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 1; i < 4; i++) begin
      expect_rd(w(300 + i), 1'b0);
      step(1'b0, 1'b0, '0, 1'b1);
    end
    chk("d4_empty", 32'(empty), 1);

    // Lower clamp: slice_width 2 -> depth 2
    slice_width = 12'd2;
    err_clr = 1'b1;
    step(1'b1, 1'b1, w(400), 1'b0);
    step(1'b1, 1'b0, w(401), 1'b0);
    chk("d2_full", 32'(full), 1);
    chk("d2_ovf_before", 32'(overflow), 0);
    step(1'b1, 1'b0, w(402), 1'b0);
    chk("d2_ovf", 32'(overflow), 1);
    chk("d2_fullness", 32'(fullness), 2);
    expect_rd(w(400), 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    expect_rd(w(401), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);

    // Upper clamp: 4000>>1 -> 1280
    slice_width = 12'd4000;
    step(1'b1, 1'b1, w(500), 1'b0);
    for (int i = 1; i < 1280; i++) begin
      step(1'b1, 1'b0, w(500 + i), 1'b0);
      if (i == 1276) chk("d1280_af_at1277", 32'(almost_full), 0);
      if (i == 1278) chk("d1280_full_at1279", 32'(full), 0);
    end
    chk("d1280_fullness", 32'(fullness), 1280);
    chk("d1280_full", 32'(full), 1);
    chk("d1280_af", 32'(almost_full), 1);

    // Margin beyond depth pins almost_full even when empty
    slice_width = 12'd16;
    step(1'b1, 1'b1, w(600), 1'b0);
    chk("flush_fullness", 32'(fullness), 1);
    af_margin = 11'd1500;
    expect_rd(w(600), 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    idle();
    chk("bigmargin_empty", 32'(empty), 1);
    chk("bigmargin_af", 32'(almost_full), 1);

    // Reset mid-operation
    af_margin = 11'd2;
    step(1'b1, 1'b0, w(700), 1'b0);
    step(1'b1, 1'b0, w(701), 1'b0);
    rst = 1'b1;
    idle();
    chk("mid_rst_fullness", 32'(fullness), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_ovf", 32'(overflow), 0);
    chk("mid_rst_af", 32'(almost_full), 0);
    rst = 1'b0;
    idle(); idle();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
